// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the AHB-to-Avalon bridge state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

endpackage

// File: rtl/ahb_avm_lane.sv
// Byte-lane enables and size/alignment legality for one AHB address phase.
// Purely combinational so any AHB slave can reuse it at its accept point.
module ahb_avm_lane #(
   parameter int DW = 32,
   localparam int NB = DW / 8,
   localparam int LB = $clog2(NB)
) (
   input  logic [LB-1:0] addr_lo_i,
   input  logic [2:0]    hsize_i,
   output logic [NB-1:0] byteen_o,
   output logic          legal_o
);

   logic size_ok;

   assign size_ok = (hsize_i <= 3'(LB));

   always_comb begin
      legal_o = size_ok;
      for (int j = 0; j < LB; j++) begin
         if ((3'(j) < hsize_i) && addr_lo_i[j]) begin
            legal_o = 1'b0;
         end
      end
   end

   // A lane is enabled when it lies in the same hsize-sized block as the address.
   always_comb begin
      byteen_o = '0;
      if (size_ok) begin
         for (int i = 0; i < NB; i++) begin
            if ((LB'(i) >> hsize_i) == (addr_lo_i >> hsize_i)) begin
               byteen_o[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ahb_avm_bridge.sv
// AHB-Lite slave to Avalon-MM master bridge, one outstanding transfer.
// Optional waitrequest watchdog enabled by defining AHB_AVM_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no transfer in data phase, zero-wait OKAY
// ST_READ  | avm_read asserted, data phase stretched by waitrequest
// ST_WRITE | avm_write asserted, data phase stretched by waitrequest
// ST_ERR1  | first ERROR cycle, hreadyout low
// ST_ERR2  | second ERROR cycle, hreadyout high, may accept next transfer
module ahb_avm_bridge
   import ahb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic            hclk,
   input  logic            hresetn,
   input  logic            hsel,
   input  logic [AW-1:0]   haddr,
   input  logic [1:0]      htrans,
   input  logic            hwrite,
   input  logic [2:0]      hsize,
   input  logic [DW-1:0]   hwdata,
   input  logic            hready,
   output logic            hreadyout,
   output logic            hresp,
   output logic [DW-1:0]   hrdata,
   output logic [AW-1:0]   avm_address,
   output logic            avm_read,
   output logic            avm_write,
   output logic [DW-1:0]   avm_writedata,
   output logic [DW/8-1:0] avm_byteenable,
   input  logic [DW-1:0]   avm_readdata,
   input  logic            avm_waitrequest
);

   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);

   bridge_state_e state_q, state_d, tgt;
   logic [AW-1:0] addr_q, addr_d;
   logic [NB-1:0] be_q, be_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;

   logic [NB-1:0] lane_be;
   logic          lane_legal;
   logic          accept;
   logic          busy;
   logic          addr_slot;
   logic          issue;
   logic          timeout_hit;
   logic          unused_htrans0;

   ahb_avm_lane #(.DW(DW)) u_lane (
      .addr_lo_i (haddr[LB-1:0]),
      .hsize_i   (hsize),
      .byteen_o  (lane_be),
      .legal_o   (lane_legal)
   );

   assign unused_htrans0 = htrans[0];
   assign accept         = hsel && hready && htrans[1];
   assign busy           = (state_q == ST_READ) || (state_q == ST_WRITE);
   // An address phase can only be taken when no data phase is still pending.
   assign addr_slot      = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                           (busy && !avm_waitrequest);
   assign issue          = addr_slot && accept && lane_legal;

`ifdef AHB_AVM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (issue) begin
         cnt_d = '0;
      end else if (busy && avm_waitrequest) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_hit = busy && avm_waitrequest && (cnt_q == TW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      tgt = ST_IDLE;
      if (accept) begin
         if (!lane_legal) begin
            tgt = ST_ERR1;
         end else if (hwrite) begin
            tgt = ST_WRITE;
         end else begin
            tgt = ST_READ;
         end
      end

      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_ERR2: state_d = tgt;
         ST_READ, ST_WRITE: begin
            if (!avm_waitrequest) begin
               state_d = tgt;
            end else if (timeout_hit) begin
               state_d = ST_ERR1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase

      addr_d = addr_q;
      be_d   = be_q;
      if (issue) begin
         addr_d = {haddr[AW-1:LB], LB'(0)};
         be_d   = lane_be;
      end
      rd_d = (state_d == ST_READ);
      wr_d = (state_d == ST_WRITE);
   end

   always_comb begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = '0;
      unique case (state_q)
         ST_READ: begin
            hreadyout = !avm_waitrequest;
            hrdata    = avm_readdata;
         end
         ST_WRITE: hreadyout = !avm_waitrequest;
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign avm_address    = addr_q;
   assign avm_byteenable = be_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = hwdata;

endmodule

// File: tb/tb_ahb_avm_bridge.sv
// Directed bench for ahb_avm_bridge with a small byte-enabled Avalon RAM.
module tb_ahb_avm_bridge;
   import ahb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          hclk = 1'b0;
   logic          hresetn;
   logic          hsel;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [DW-1:0] hwdata;
   logic          hready;
   logic          hreadyout;
   logic          hresp;
   logic [DW-1:0] hrdata;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic          avm_write;
   logic [DW-1:0] avm_writedata;
   logic [3:0]    avm_byteenable;
   logic [DW-1:0] avm_readdata;
   logic          avm_waitrequest;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [16];

   always #5 hclk = ~hclk;

   assign hready       = hreadyout;
   assign avm_readdata = mem[avm_address[5:2]];

   always @(posedge hclk) begin
      if (avm_write && !avm_waitrequest) begin
         for (int b = 0; b < 4; b++) begin
            if (avm_byteenable[b]) mem[avm_address[5:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
         end
      end
   end

   ahb_avm_bridge #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .hclk            (hclk),
      .hresetn         (hresetn),
      .hsel            (hsel),
      .haddr           (haddr),
      .htrans          (htrans),
      .hwrite          (hwrite),
      .hsize           (hsize),
      .hwdata          (hwdata),
      .hready          (hready),
      .hreadyout       (hreadyout),
      .hresp           (hresp),
      .hrdata          (hrdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
   endtask

   task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
      hsel   = 1'b1;
      htrans = HTRANS_NONSEQ;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      hresetn         = 1'b0;
      bus_idle();
      haddr           = '0;
      hsize           = HSIZE_BYTE;
      hwdata          = '0;
      avm_waitrequest = 1'b0;

      #2;
      check_val("rst_hreadyout", hreadyout, 1);
      check_val("rst_hresp", hresp, 0);
      check_val("rst_hrdata", hrdata, 0);
      check_val("rst_rdwr", {avm_read, avm_write}, 0);
      check_val("rst_address", avm_address, 0);
      check_val("rst_byteen", avm_byteenable, 0);

      @(posedge hclk);
      tick();
      hresetn = 1'b1;

      // word write then read at 0x10
      tick(); addr_ph(32'h10, 1'b1, HSIZE_WORD);
      @(negedge hclk); check_val("wr_addrph_rdy", hreadyout, 1);
      tick(); bus_idle(); hwdata = 32'hDEADBEEF;
      @(negedge hclk);
      check_val("wr_avm_write", avm_write, 1);
      check_val("wr_avm_read", avm_read, 0);
      check_val("wr_be", avm_byteenable, 4'hF);
      check_val("wr_address", avm_address, 32'h10);
      check_val("wr_wdata", avm_writedata, 32'hDEADBEEF);
      check_val("wr_rdy", hreadyout, 1);
      tick(); addr_ph(32'h10, 1'b0, HSIZE_WORD);
      @(negedge hclk); check_val("wr_pulse_end", avm_write, 0);
      tick(); bus_idle();
      @(negedge hclk);
      check_val("rd_avm_read", avm_read, 1);
      check_val("rd_hrdata", hrdata, 32'hDEADBEEF);
      check_val("rd_rdy", hreadyout, 1);
      check_val("rd_hresp", hresp, 0);
      tick();
      @(negedge hclk);
      check_val("rd_pulse_end", avm_read, 0);
      check_val("rd_hrdata_idle", hrdata, 0);

      // byte write 0x13 pipelined with halfword write 0x12
      tick(); addr_ph(32'h13, 1'b1, HSIZE_BYTE);
      tick(); addr_ph(32'h12, 1'b1, HSIZE_HALF); hwdata = 32'h11223344;
      @(negedge hclk);
      check_val("byte_address", avm_address, 32'h10);
      check_val("byte_be", avm_byteenable, 4'h8);
      check_val("byte_write", avm_write, 1);
      tick(); bus_idle(); hwdata = 32'h55667788;
      @(negedge hclk);
      check_val("half_address", avm_address, 32'h10);
      check_val("half_be", avm_byteenable, 4'hC);
      check_val("half_write", avm_write, 1);
      tick();
      @(negedge hclk); check_val("half_end", avm_write, 0);

      // read with three waitrequest cycles
      tick(); addr_ph(32'h10, 1'b0, HSIZE_WORD);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 0) begin bus_idle(); avm_waitrequest = 1'b1; end
         @(negedge hclk);
         check_val("stall_rdy", hreadyout, 0);
         check_val("stall_read", avm_read, 1);
      end
      tick(); avm_waitrequest = 1'b0;
      @(negedge hclk);
      check_val("stall_done_rdy", hreadyout, 1);
      check_val("stall_hrdata", hrdata, 32'h5566BEEF);
      tick();
      @(negedge hclk); check_val("stall_end", avm_read, 0);

      // misaligned halfword read, then size 3 write
      for (int e = 0; e < 2; e++) begin
         tick();
         if (e == 0) addr_ph(32'h11, 1'b0, HSIZE_HALF);
         else        addr_ph(32'h10, 1'b1, HSIZE_DWORD);
         tick(); bus_idle();
         @(negedge hclk);
         check_val("err1_hresp", hresp, 1);
         check_val("err1_rdy", hreadyout, 0);
         check_val("err1_rdwr", {avm_read, avm_write}, 0);
         tick();
         @(negedge hclk);
         check_val("err2_hresp", hresp, 1);
         check_val("err2_rdy", hreadyout, 1);
         check_val("err2_rdwr", {avm_read, avm_write}, 0);
         tick();
         @(negedge hclk);
         check_val("err_after_hresp", hresp, 0);
         check_val("err_after_rdwr", {avm_read, avm_write}, 0);
      end

      // four back-to-back writes
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) addr_ph(32'h20 + 32'(4 * i), 1'b1, HSIZE_WORD);
         else       bus_idle();
         if (i > 0) hwdata = 32'hA000_0000 + 32'(i);
         @(negedge hclk);
         if (i > 0) begin
            check_val("b2b_write", avm_write, 1);
            check_val("b2b_address", avm_address, 32'h20 + 32'(4 * (i - 1)));
            check_val("b2b_wdata", avm_writedata, 32'hA000_0000 + 32'(i));
         end
      end
      tick();
      @(negedge hclk); check_val("b2b_end", avm_write, 0);

      // reset asserted in the middle of a stalled write
      tick(); addr_ph(32'h30, 1'b1, HSIZE_WORD);
      tick(); bus_idle(); avm_waitrequest = 1'b1; hwdata = 32'h0BAD_0BAD;
      @(negedge hclk);
      check_val("rststall_write", avm_write, 1);
      check_val("rststall_rdy", hreadyout, 0);
      #2 hresetn = 1'b0;
      #1;
      check_val("rstmid_write", avm_write, 0);
      check_val("rstmid_rdy", hreadyout, 1);
      check_val("rstmid_address", avm_address, 0);
      check_val("rstmid_be", avm_byteenable, 0);
      check_val("rstmid_hresp", hresp, 0);
      tick(); avm_waitrequest = 1'b0;
      tick(); hresetn = 1'b1;

`ifdef AHB_AVM_TIMEOUT_EN
      begin
         int n;
         tick(); addr_ph(32'h10, 1'b0, HSIZE_WORD);
         tick(); bus_idle(); avm_waitrequest = 1'b1;
         n = 0;
         @(negedge hclk);
         while (avm_read && n < 20) begin
            n++;
            @(negedge hclk);
         end
         check_val("to_req_cycles", 64'(n), 8);
         check_val("to_err1_hresp", hresp, 1);
         check_val("to_err1_rdy", hreadyout, 0);
         @(negedge hclk);
         check_val("to_err2_hresp", hresp, 1);
         check_val("to_err2_rdy", hreadyout, 1);
         avm_waitrequest = 1'b0;
      end
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
